// File: rtl/uart_rx.sv
// UART receive stage: 16x oversampled, 2-flop synchronised line input.
// Deserialises start + DBIT data (LSB first) + stop and pulses rx_done_tick.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_d;
    logic            ferr_d;
    logic            done_d;
    logic            sync1_q;
    logic            rx_s;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s    <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            b_q          <= b_d;
            dout         <= dout_d;
            frame_err    <= ferr_d;
            rx_done_tick <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout;
        ferr_d  = frame_err;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == 4'd7) begin
                        // Mid start bit: still low means a real frame.
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == 4'd15) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d = IDLE;
                        dout_d  = b_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random frames against a frame-level model.
// Expected bytes, error flags and done-pulse timing come from the frame rules.
module tb_uart_rx;

    localparam int DBIT        = 8;
    localparam int SB_TICK     = 16;
    localparam int FRAME_TICKS = 8 + 16 * DBIT + SB_TICK;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         fall;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       ferr;
    } pulse_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;

    int     cyc = 0;
    int     div = 4;
    bit     tick_en = 1'b1;
    int     fall_cyc = 0;
    int     tests = 0;
    int     fails = 0;
    int     tick_q[$];
    pulse_t pulses[$];
    exp_t   exp_q[$];
    logic [7:0] last_byte;

    uart_rx #(
        .DBIT(DBIT),
        .SB_TICK(SB_TICK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .s_tick(s_tick),
        .rx_done_tick(rx_done_tick),
        .dout(dout),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin : ticker
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1 >= div) ? 0 : ph + 1;
            s_tick = tick_en && (ph == 0);
        end
    end

    initial begin : monitor
        forever begin
            @(posedge clk);
            cyc++;
            if (s_tick) tick_q.push_back(cyc);
            #1;
            if (rx_done_tick === 1'b1)
                pulses.push_back('{cyc, dout, frame_err});
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input logic v);
        @(negedge clk);
        if (rx === 1'b1 && v == 1'b0) fall_cyc = cyc;
        rx = v;
    endtask

    task automatic wait_ticks(input int k);
        int c = 0;
        int lim = k * 8 + 200;
        while (c < k && lim > 0) begin
            @(posedge clk);
            lim--;
            if (s_tick) c++;
        end
        if (c < k) check("tick_wait", c, k);
    endtask

    // Edge on which the done pulse must appear: 2 sync clocks, 1 clock to
    // enter START, then FRAME_TICKS ticks counted from the following edge.
    function automatic int expected_edge(input int fall);
        int c = 0;
        foreach (tick_q[j]) begin
            if (tick_q[j] >= fall + 4) begin
                c++;
                if (c == FRAME_TICKS) return tick_q[j];
            end
        end
        return -1;
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input int pause_at);
        set_rx(1'b0);
        exp_q.push_back('{d, !stop_ok, fall_cyc});
        wait_ticks(16);
        for (int i = 0; i < DBIT; i++) begin
            if (i == pause_at) begin
                @(negedge clk);
                tick_en = 1'b0;
                repeat (150) @(negedge clk);
                tick_en = 1'b1;
            end
            set_rx(d[i]);
            wait_ticks(16);
        end
        if (stop_ok) begin
            set_rx(1'b1);
            wait_ticks(16);
        end else begin
            // Low across the sample point, back high before the bit ends.
            set_rx(1'b0);
            wait_ticks(12);
            set_rx(1'b1);
            wait_ticks(4);
        end
    endtask

    task automatic check_frames(input int n);
        check("pulse_count", pulses.size(), n);
        for (int i = 0; i < n && i < pulses.size() && i < exp_q.size(); i++) begin
            check("dout", pulses[i].data, exp_q[i].data);
            check("frame_err", pulses[i].ferr, exp_q[i].ferr);
            check("latency", pulses[i].cyc, expected_edge(exp_q[i].fall));
            last_byte = exp_q[i].data;
        end
        pulses.delete();
        exp_q.delete();
    endtask

    initial begin : stim
        logic [7:0] d;
        bit         ok;
        int         gap;
        int         nbrk;

        repeat (3) @(negedge clk);
        check("rst_done", rx_done_tick, 1'b0);
        check("rst_dout", dout, 8'h00);
        check("rst_ferr", frame_err, 1'b0);
        reset = 1'b0;
        wait_ticks(20);

        send_frame(8'hA5, 1'b1, -1);
        check_frames(1);
        wait_ticks(16);
        check("idle_done", rx_done_tick, 1'b0);

        set_rx(1'b0);
        wait_ticks(5);
        set_rx(1'b1);
        wait_ticks(40);
        check("glitch_pulses", pulses.size(), 0);
        check("glitch_dout", dout, last_byte);

        send_frame(8'h3C, 1'b0, -1);
        check_frames(1);
        wait_ticks(16);
        send_frame(8'h81, 1'b1, -1);
        check_frames(1);
        check("hold_dout", dout, 8'h81);
        check("hold_ferr", frame_err, 1'b0);

        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h55, 1'b1, -1);
        check_frames(3);

        d = 8'h7E;
        set_rx(1'b0);
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            set_rx(d[i]);
            wait_ticks(16);
        end
        set_rx(d[4]);
        wait_ticks(8);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_dout", dout, 8'h00);
        check("abort_ferr", frame_err, 1'b0);
        check("abort_done", rx_done_tick, 1'b0);
        set_rx(1'b1);
        wait_ticks(40);
        check("abort_pulses", pulses.size(), 0);
        send_frame(8'h12, 1'b1, -1);
        check_frames(1);

        div = 3;
        wait_ticks(4);
        send_frame(8'hC3, 1'b1, 5);
        check_frames(1);

        for (int k = 0; k < 8; k++) begin
            div = $urandom_range(1, 6);
            wait_ticks(2);
            d  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(d, ok, -1);
            check_frames(1);
            gap = ok ? $urandom_range(0, 20) : 16 + $urandom_range(0, 8);
            if (gap > 0) wait_ticks(gap);
        end

        div = 4;
        wait_ticks(16);
        set_rx(1'b0);
        wait_ticks(30 * 16);
        nbrk = (30 * 16) / FRAME_TICKS;
        check("break_pulses", pulses.size(), nbrk);
        foreach (pulses[i]) begin
            check("break_dout", pulses[i].data, 8'h00);
            check("break_ferr", pulses[i].ferr, 1'b1);
        end
        set_rx(1'b1);
        wait_ticks(200);
        pulses.delete();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
